// File: rtl/ip_rcv.sv
`timescale 1ns/1ps
// IPv4 receive stage: parses/validates the header, skips options, forwards the IP payload.
// Latency: 1 cycle from input accept to udp_axis_tvalid_out (single output register).
// Backpressure: ip_axis_tready_out follows the output register only in PAYLOAD; header/drain always ready.
module ip_rcv #(
   parameter logic [31:0] LOCAL_IP   = 32'hC0A8010A,
   parameter bit          CHECK_CSUM = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [7:0]  ip_axis_tdata_in,
   input  logic        ip_axis_tvalid_in,
   input  logic        ip_axis_tlast_in,
   output logic        ip_axis_tready_out,
   output logic [7:0]  udp_axis_tdata_out,
   output logic        udp_axis_tvalid_out,
   output logic        udp_axis_tlast_out,
   input  logic        udp_axis_tready_in,
   output logic [31:0] src_ip_out,
   output logic [15:0] payload_len_out,
   output logic        hdr_err_out,
   output logic [15:0] drop_cnt_out
);

   localparam logic [1:0] S_HDR   = 2'd0;
   localparam logic [1:0] S_OPT   = 2'd1;
   localparam logic [1:0] S_PAY   = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]  state;
   logic [5:0]  cnt;          // header byte index, 0..59
   logic [3:0]  ver;
   logic [3:0]  ihl;
   logic [15:0] tot_len;
   logic [13:0] frag;         // MF flag plus 13-bit fragment offset
   logic [7:0]  proto;
   logic [31:0] src_sh;
   logic [31:0] dst_sh;
   logic [15:0] csum_acc;
   logic [7:0]  csum_hi;
   logic [15:0] rem;

   logic        accept;
   logic [5:0]  hdr_len;
   logic [16:0] sum17;
   logic [15:0] csum_next;
   logic [31:0] dst_now;
   logic        last_hdr_byte;
   logic        hdr_ok;
   logic [15:0] plen_calc;

   // Input is held off only when the payload output register is full and stalled.
   assign ip_axis_tready_out = (state == S_PAY) ? (!udp_axis_tvalid_out || udp_axis_tready_in) : 1'b1;
   assign accept = ip_axis_tvalid_in && ip_axis_tready_out;

   // Header evaluation terms; the checksum and dst include the byte being accepted now.
   always_comb begin
      hdr_len   = {ihl, 2'b00};
      sum17     = {1'b0, csum_acc} + {1'b0, csum_hi, ip_axis_tdata_in};
      csum_next = sum17[15:0] + {15'd0, sum17[16]};
      dst_now   = (state == S_HDR) ? {dst_sh[23:0], ip_axis_tdata_in} : dst_sh;
      plen_calc = tot_len - {10'd0, hdr_len};
      last_hdr_byte = 1'b0;
      if (state == S_HDR)
         last_hdr_byte = (cnt == 6'd19) && (ihl <= 4'd5);
      else if (state == S_OPT)
         last_hdr_byte = (cnt == hdr_len - 6'd1);
      hdr_ok = (ver == 4'd4) && (ihl >= 4'd5) && (proto == 8'd17) &&
               ((dst_now == LOCAL_IP) || (dst_now == 32'hFFFF_FFFF)) &&
               (frag == 14'd0) &&
               ({1'b0, tot_len} >= ({11'd0, hdr_len} + 17'd8)) &&
               (!CHECK_CSUM || (csum_next == 16'hFFFF));
   end

   // Frame parser, output register and status counters.
   always_ff @(posedge clk) begin
      if (reset) begin
         state               <= S_HDR;
         cnt                 <= 6'd0;
         ver                 <= 4'd0;
         ihl                 <= 4'd0;
         tot_len             <= 16'd0;
         frag                <= 14'd0;
         proto               <= 8'd0;
         src_sh              <= 32'd0;
         dst_sh              <= 32'd0;
         csum_acc            <= 16'd0;
         csum_hi             <= 8'd0;
         rem                 <= 16'd0;
         udp_axis_tdata_out  <= 8'd0;
         udp_axis_tvalid_out <= 1'b0;
         udp_axis_tlast_out  <= 1'b0;
         src_ip_out          <= 32'd0;
         payload_len_out     <= 16'd0;
         hdr_err_out         <= 1'b0;
         drop_cnt_out        <= 16'd0;
      end else begin
         hdr_err_out <= 1'b0;
         if (udp_axis_tvalid_out && udp_axis_tready_in)
            udp_axis_tvalid_out <= 1'b0;

         case (state)
            S_HDR, S_OPT: begin
               if (accept) begin
                  cnt <= cnt + 6'd1;
                  if (!cnt[0]) csum_hi  <= ip_axis_tdata_in;
                  else         csum_acc <= csum_next;
                  if (state == S_HDR) begin
                     case (cnt)
                        6'd0:  {ver, ihl}    <= ip_axis_tdata_in;
                        6'd2:  tot_len[15:8] <= ip_axis_tdata_in;
                        6'd3:  tot_len[7:0]  <= ip_axis_tdata_in;
                        6'd6:  frag[13:8]    <= ip_axis_tdata_in[5:0];
                        6'd7:  frag[7:0]     <= ip_axis_tdata_in;
                        6'd9:  proto         <= ip_axis_tdata_in;
                        6'd12, 6'd13, 6'd14, 6'd15:
                               src_sh <= {src_sh[23:0], ip_axis_tdata_in};
                        6'd16, 6'd17, 6'd18, 6'd19:
                               dst_sh <= {dst_sh[23:0], ip_axis_tdata_in};
                        default: ;
                     endcase
                  end
                  if (ip_axis_tlast_in) begin
                     // Frame ended inside the header: nothing to forward.
                     hdr_err_out  <= 1'b1;
                     drop_cnt_out <= drop_cnt_out + 16'd1;
                     state        <= S_HDR;
                     cnt          <= 6'd0;
                     csum_acc     <= 16'd0;
                  end else if (last_hdr_byte) begin
                     cnt      <= 6'd0;
                     csum_acc <= 16'd0;
                     if (hdr_ok) begin
                        src_ip_out      <= src_sh;
                        payload_len_out <= plen_calc;
                        rem             <= plen_calc;
                        state           <= S_PAY;
                     end else begin
                        hdr_err_out  <= 1'b1;
                        drop_cnt_out <= drop_cnt_out + 16'd1;
                        state        <= S_DRAIN;
                     end
                  end else if ((state == S_HDR) && (cnt == 6'd19)) begin
                     state <= S_OPT;
                  end
               end
            end
            S_PAY: begin
               if (accept) begin
                  udp_axis_tdata_out  <= ip_axis_tdata_in;
                  udp_axis_tvalid_out <= 1'b1;
                  udp_axis_tlast_out  <= (rem == 16'd1) || ip_axis_tlast_in;
                  rem                 <= rem - 16'd1;
                  if (rem == 16'd1) begin
                     state <= ip_axis_tlast_in ? S_HDR : S_DRAIN;
                  end else if (ip_axis_tlast_in) begin
                     // Truncated payload: close the packet early and flag it.
                     hdr_err_out <= 1'b1;
                     state       <= S_HDR;
                  end
               end
            end
            default: begin
               if (accept && ip_axis_tlast_in)
                  state <= S_HDR;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ip_rcv.sv
`timescale 1ns/1ps
// Directed bench for ip_rcv: hand-built frames, payload scoreboard, stall-hold checks.
// Two instances share the input stream; the second ignores the header checksum.
// Downstream ready is either held high or toggled in a 1,0,0,1 pattern.
module tb_ip_rcv;

   typedef logic [7:0] bq_t[$];

   localparam logic [31:0] LOCAL = 32'hC0A8010A;
   localparam logic [31:0] SRC   = 32'h0A000001;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [7:0]  ip_dat = 8'd0;
   logic        ip_vld = 1'b0;
   logic        ip_last = 1'b0;
   logic        ip_rdy;
   logic [7:0]  udp_dat;
   logic        udp_vld;
   logic        udp_last;
   logic        udp_rdy = 1'b1;
   logic [31:0] src_ip;
   logic [15:0] plen;
   logic        hdr_err;
   logic [15:0] drop_cnt;

   logic        ip_rdy1;
   logic [7:0]  udp_dat1;
   logic        udp_vld1;
   logic        udp_last1;
   logic [31:0] src_ip1;
   logic [15:0] plen1;
   logic        hdr_err1;
   logic [15:0] drop_cnt1;

   int nvec = 0;
   int nerr = 0;
   int err_cnt = 0;
   int n1 = 0;
   int stalls = 0;
   logic tog_en = 1'b0;
   logic [8:0] rxq[$];
   logic       hold_pend = 1'b0;
   logic [31:0] hold_val = 32'd0;

   ip_rcv #(.LOCAL_IP(LOCAL), .CHECK_CSUM(1'b1)) dut (
      .clk(clk), .reset(reset),
      .ip_axis_tdata_in(ip_dat), .ip_axis_tvalid_in(ip_vld), .ip_axis_tlast_in(ip_last),
      .ip_axis_tready_out(ip_rdy),
      .udp_axis_tdata_out(udp_dat), .udp_axis_tvalid_out(udp_vld), .udp_axis_tlast_out(udp_last),
      .udp_axis_tready_in(udp_rdy),
      .src_ip_out(src_ip), .payload_len_out(plen), .hdr_err_out(hdr_err), .drop_cnt_out(drop_cnt)
   );

   ip_rcv #(.LOCAL_IP(LOCAL), .CHECK_CSUM(1'b0)) dut_nocsum (
      .clk(clk), .reset(reset),
      .ip_axis_tdata_in(ip_dat), .ip_axis_tvalid_in(ip_vld), .ip_axis_tlast_in(ip_last),
      .ip_axis_tready_out(ip_rdy1),
      .udp_axis_tdata_out(udp_dat1), .udp_axis_tvalid_out(udp_vld1), .udp_axis_tlast_out(udp_last1),
      .udp_axis_tready_in(udp_rdy),
      .src_ip_out(src_ip1), .payload_len_out(plen1), .hdr_err_out(hdr_err1), .drop_cnt_out(drop_cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Sample between edges: capture transfers, check stalled output holds, count error pulses.
   always @(negedge clk) begin
      if (hold_pend)
         chk("hold", {22'd0, udp_vld, udp_last, udp_dat}, hold_val);
      if (udp_vld && udp_rdy) rxq.push_back({udp_last, udp_dat});
      hold_pend = udp_vld && !udp_rdy;
      hold_val  = {22'd0, 1'b1, udp_last, udp_dat};
      if (hdr_err) err_cnt++;
      if (udp_vld1 && udp_rdy) n1++;
   end

   // Downstream ready: constant 1 or the repeating 1,0,0,1 pattern.
   initial begin
      int k;
      logic [3:0] pat;
      k = 0;
      pat = 4'b1001;
      forever begin
         @(posedge clk);
         #1;
         if (tog_en) begin
            udp_rdy = pat[3 - (k % 4)];
            k++;
         end else begin
            udp_rdy = 1'b1;
         end
      end
   end

   function automatic bq_t mk(input logic [7:0] vi, input logic [15:0] tl, input logic [15:0] fr,
                              input logic [7:0] pr, input logic [31:0] ds, input int nopt,
                              input int npay, input int npad, input logic bad);
      bq_t q;
      logic [31:0] s;
      logic [15:0] c;
      q.push_back(vi);        q.push_back(8'h00);
      q.push_back(tl[15:8]);  q.push_back(tl[7:0]);
      q.push_back(8'h12);     q.push_back(8'h34);
      q.push_back(fr[15:8]);  q.push_back(fr[7:0]);
      q.push_back(8'h40);     q.push_back(pr);
      q.push_back(8'h00);     q.push_back(8'h00);
      q.push_back(SRC[31:24]); q.push_back(SRC[23:16]); q.push_back(SRC[15:8]); q.push_back(SRC[7:0]);
      q.push_back(ds[31:24]);  q.push_back(ds[23:16]);  q.push_back(ds[15:8]);  q.push_back(ds[7:0]);
      for (int i = 0; i < nopt; i++) q.push_back(8'hA0 + 8'(i));
      s = 32'd0;
      for (int i = 0; i < 20 + nopt; i += 2) s = s + {16'd0, q[i], q[i+1]};
      while (s[31:16] != 16'd0) s = {16'd0, s[15:0]} + {16'd0, s[31:16]};
      c = ~s[15:0];
      if (bad) c = c + 16'd1;
      q[10] = c[15:8];
      q[11] = c[7:0];
      for (int i = 0; i < npay; i++) q.push_back(8'(i));
      for (int i = 0; i < npad; i++) q.push_back(8'hEE);
      return q;
   endfunction

   task automatic send_frame(input bq_t f);
      int t;
      for (int i = 0; i < f.size(); i++) begin
         @(posedge clk);
         #1;
         ip_dat  = f[i];
         ip_vld  = 1'b1;
         ip_last = (i == f.size() - 1);
         t = 0;
         @(negedge clk);
         while (!ip_rdy) begin
            stalls++;
            t++;
            if (t > 200) begin
               chk("accept_timeout", 32'd0, 32'd1);
               break;
            end
            @(negedge clk);
         end
      end
      @(posedge clk);
      #1;
      ip_vld  = 1'b0;
      ip_last = 1'b0;
      repeat (20) @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_pay(input string tag, input int n, input int first);
      chk({tag, "_count"}, rxq.size(), n);
      for (int i = 0; i < rxq.size() && i < n; i++)
         chk(tag, {23'd0, rxq[i]}, ((i == n - 1) ? 32'd256 : 32'd0) + ((first + i) & 255));
      rxq.delete();
   endtask

   initial begin
      bq_t f;
      int e0, d1;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_tready", {31'd0, ip_rdy}, 32'd1);
      chk("rst_tvalid", {31'd0, udp_vld}, 32'd0);
      chk("rst_tlast", {31'd0, udp_last}, 32'd0);
      chk("rst_src", src_ip, 32'd0);
      chk("rst_plen", {16'd0, plen}, 32'd0);
      chk("rst_err", {31'd0, hdr_err}, 32'd0);
      chk("rst_drop", {16'd0, drop_cnt}, 32'd0);

      // Valid datagram, 16-byte payload.
      send_frame(mk(8'h45, 16'h0024, 16'h0000, 8'd17, LOCAL, 0, 16, 0, 1'b0));
      check_pay("valid", 16, 0);
      chk("valid_plen", {16'd0, plen}, 32'd16);
      chk("valid_src", src_ip, SRC);
      chk("valid_drop", {16'd0, drop_cnt}, 32'd0);

      // TCP datagram is dropped, then a good one passes.
      e0 = err_cnt;
      send_frame(mk(8'h45, 16'h0024, 16'h0000, 8'd6, LOCAL, 0, 16, 0, 1'b0));
      check_pay("tcp", 0, 0);
      chk("tcp_err", err_cnt - e0, 32'd1);
      chk("tcp_drop", {16'd0, drop_cnt}, 32'd1);
      send_frame(mk(8'h45, 16'h0024, 16'h0000, 8'd17, 32'hFFFF_FFFF, 0, 16, 0, 1'b0));
      check_pay("after_tcp", 16, 0);

      // Corrupted checksum: dropped with checking, forwarded without.
      d1 = n1;
      send_frame(mk(8'h45, 16'h0024, 16'h0000, 8'd17, LOCAL, 0, 16, 0, 1'b1));
      check_pay("badcsum", 0, 0);
      chk("badcsum_drop", {16'd0, drop_cnt}, 32'd2);
      chk("nocsum_fwd", n1 - d1, 32'd16);
      chk("nocsum_drop", {16'd0, drop_cnt1}, 32'd1);

      // 32-byte datagram in a 46-byte padded frame.
      stalls = 0;
      send_frame(mk(8'h45, 16'h0020, 16'h0000, 8'd17, LOCAL, 0, 12, 14, 1'b0));
      check_pay("padded", 12, 0);
      chk("padded_plen", {16'd0, plen}, 32'd12);
      chk("padded_stalls", stalls, 32'd0);

      // IHL=6 with 4 option bytes.
      send_frame(mk(8'h46, 16'h0028, 16'h0000, 8'd17, LOCAL, 4, 16, 0, 1'b0));
      check_pay("options", 16, 0);
      chk("options_plen", {16'd0, plen}, 32'd16);

      // Fragment (MF set) is rejected.
      send_frame(mk(8'h45, 16'h0024, 16'h2000, 8'd17, LOCAL, 0, 16, 0, 1'b0));
      check_pay("frag", 0, 0);
      chk("frag_drop", {16'd0, drop_cnt}, 32'd3);

      // Downstream ready toggling 1,0,0,1.
      tog_en = 1'b1;
      send_frame(mk(8'h45, 16'h0024, 16'h0000, 8'd17, LOCAL, 0, 16, 0, 1'b0));
      check_pay("toggle", 16, 0);

      // Early tlast at payload byte 5 of 16.
      e0 = err_cnt;
      f = mk(8'h45, 16'h0024, 16'h0000, 8'd17, LOCAL, 0, 16, 0, 1'b0);
      while (f.size() > 25) f.pop_back();
      send_frame(f);
      check_pay("early", 5, 0);
      chk("early_err", err_cnt - e0, 32'd1);
      chk("early_drop", {16'd0, drop_cnt}, 32'd3);
      tog_en = 1'b0;

      // Frame ends inside the header.
      e0 = err_cnt;
      f = mk(8'h45, 16'h0024, 16'h0000, 8'd17, LOCAL, 0, 16, 0, 1'b0);
      while (f.size() > 10) f.pop_back();
      send_frame(f);
      check_pay("trunc_hdr", 0, 0);
      chk("trunc_hdr_err", err_cnt - e0, 32'd1);
      chk("trunc_hdr_drop", {16'd0, drop_cnt}, 32'd4);

      // Recovery after truncation.
      send_frame(mk(8'h45, 16'h0024, 16'h0000, 8'd17, LOCAL, 0, 16, 0, 1'b0));
      check_pay("recover", 16, 0);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule

// File: doc/ip_rcv.md
Name: ip_rcv

Overview:
- IPv4 receive stage directly upstream of the UDP receive stage.
- Consumes the byte stream of one IPv4 datagram per frame, with Ethernet header already stripped and ethertype 0x0800 already filtered.
- Parses and validates the IPv4 header, skips options, and forwards only the IP payload (UDP header plus data) as an 8-bit AXI-Stream.
- Discards Ethernet padding and rejected datagrams.

Parameters:
- LOCAL_IP, 32'hC0A8010A, accepted destination address; 32'hFFFFFFFF is always accepted as well.
- CHECK_CSUM, 1, 1 = drop datagrams whose header checksum fails; 0 = ignore checksum.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ip_axis_tdata_in  in  8  IP datagram byte
- ip_axis_tvalid_in  in  1  byte valid
- ip_axis_tlast_in  in  1  last byte of Ethernet frame
- ip_axis_tready_out  out  1  byte accepted when tvalid && tready
- udp_axis_tdata_out  out  8  payload byte
- udp_axis_tvalid_out  out  1  payload valid
- udp_axis_tlast_out  out  1  last payload byte
- udp_axis_tready_in  in  1  downstream ready
- src_ip_out  out  32  source IP of the last accepted datagram; updates when the header is accepted
- payload_len_out  out  16  total_length minus IHL*4 of the last accepted datagram
- hdr_err_out  out  1  one-cycle pulse on a rejected header or a truncated payload
- drop_cnt_out  out  16  count of rejected datagrams; wraps at 0xFFFF

Behaviour:
- Reset values:
  - all outputs 0;
  - ip_axis_tready_out = 1;
  - state = HDR;
  - byte counter = 0;
  - checksum accumulator = 0.
- Reset mid-frame aborts the frame. Reset must be applied at a frame boundary; bytes following reset are parsed as a new header.

States:
- HDR: tready = 1. Capture bytes 0..19.
  - byte0 = version/IHL; bytes2-3 = total_length; bytes6-7 = flags/fragment offset; byte9 = protocol; bytes12-15 = src IP; bytes16-19 = dst IP.
  - After byte 19: if IHL > 5, go to OPT; otherwise evaluate the header.
- OPT: tready = 1. Consume (IHL-5)*4 option bytes, accumulating the checksum, then evaluate the header.
- Header evaluation happens on acceptance of the last header byte. All of the following must hold to go to PAYLOAD:
  - version == 4;
  - IHL >= 5;
  - protocol == 17;
  - dst == LOCAL_IP or dst == 255.255.255.255;
  - MF == 0 and fragment offset == 0;
  - total_length >= IHL*4 + 8;
  - checksum OK, or CHECK_CSUM == 0.
  - On pass: latch src_ip_out and payload_len_out; load the remaining counter with payload_len_out.
  - On fail: go to DRAIN; pulse hdr_err_out; increment drop_cnt_out.
- Checksum: 16-bit words formed big-endian from byte pairs; 17-bit add with end-around carry, covering all IHL*4 header bytes. Pass if the final sum == 16'hFFFF.
- PAYLOAD:
  - Single output register; ip_axis_tready_out = !udp_axis_tvalid_out || udp_axis_tready_in.
  - An accepted input byte appears on udp_axis_tdata_out the next cycle with tvalid = 1.
  - The output holds stable while tvalid && !tready.
  - Remaining counter decrements per accepted byte.
  - udp_axis_tlast_out = 1 on the byte where remaining == 1.
  - Next state: if that byte also carries ip_axis_tlast_in, go to HDR; otherwise go to DRAIN to discard padding.
- Early ip_axis_tlast_in in PAYLOAD (remaining > 1): forward that byte with udp_axis_tlast_out = 1, pulse hdr_err_out, go to HDR.
- DRAIN: tready = 1. Discard bytes until ip_axis_tlast_in is accepted, then go to HDR.
- ip_axis_tlast_in during HDR or OPT (frame shorter than the header): pulse hdr_err_out, increment drop_cnt_out, go to HDR; nothing is forwarded.
- No output bytes are produced outside PAYLOAD; header bytes are never forwarded.
- Latency: 1 cycle from input accept to output valid. Throughput: 1 byte/cycle when downstream is ready.

Test Plan:
- Valid datagram: IHL=5, total_length=0x0024, proto 17, dst=LOCAL_IP, correct checksum, 16-byte payload 0x00..0x0F -> 16 output bytes 0x00..0x0F, tlast on 0x0F, payload_len_out=16, drop_cnt_out=0.
- Protocol 6 (TCP), otherwise valid -> no output, hdr_err_out pulses once, drop_cnt_out=1, next valid datagram forwarded normally.
- Checksum corrupted by +1 with CHECK_CSUM=1 -> dropped, drop_cnt_out increments; same frame with CHECK_CSUM=0 -> forwarded.
- total_length=0x0020 sent in a 46-byte padded frame -> 12 payload bytes with tlast on the 12th; the 14 padding bytes are consumed with tready=1 and produce no output.
- IHL=6 with 4 option bytes and correct checksum -> option bytes skipped, payload starts at input byte 24.
- Valid datagram with udp_axis_tready_in toggling 1,0,0,1 repeatedly -> no byte lost or duplicated, data held stable while stalled; early ip_axis_tlast_in at payload byte 5 of 16 -> tlast on byte 5, hdr_err_out pulse.
